// File: rtl/irq_latch_ctrl_pkg.sv
// Shared constants, FSM encodings and payload types for the IRQ latch/offer front-end.
package irq_latch_ctrl_pkg;

  localparam int unsigned IRQ_W = 32;
  localparam int unsigned NUM_W = 5;

  // Internal sources merged into the external vector at these indices
  localparam int unsigned IRQ_TIMER    = 0;
  localparam int unsigned IRQ_EBREAK   = 1;
  localparam int unsigned IRQ_BUSERROR = 2;

  localparam logic [IRQ_W-1:0] MASK_RST = '1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_OFFER  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  typedef struct packed {
    logic             valid;
    logic [NUM_W-1:0] num;
  } irq_offer_t;

endpackage

// File: rtl/irq_latch_ctrl_if.sv
// Offer/accept/retire handshake between the IRQ front-end (master) and the core (slave).
interface irq_latch_ctrl_if;
  import irq_latch_ctrl_pkg::*;

  logic             irq_valid;
  logic [NUM_W-1:0] irq_num;
  logic             irq_ready;
  logic             irq_done;
  logic             in_handler;

  modport master (
    output irq_valid,
    output irq_num,
    output in_handler,
    input  irq_ready,
    input  irq_done
  );

  modport slave (
    input  irq_valid,
    input  irq_num,
    input  in_handler,
    output irq_ready,
    output irq_done
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: 32-bit request vector to 5-bit index plus any-bit flag.
module irq_prio_enc
  import irq_latch_ctrl_pkg::*;
(
  input  logic [IRQ_W-1:0] vec,
  output logic [NUM_W-1:0] num_c,
  output logic             any_c
);

  always_comb begin
    num_c = '0;
    any_c = 1'b0;
    for (int i = 0; i < int'(IRQ_W); i++) begin
      if (vec[i] && !any_c) begin
        num_c = NUM_W'(i);
        any_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_latch_ctrl.sv
// Latches and masks 32 interrupt requests and offers the lowest enabled pending one to the core,
// holding further offers until the core retires the handler.
module irq_latch_ctrl
  import irq_latch_ctrl_pkg::*;
#(
  parameter logic [IRQ_W-1:0] MASKED_IRQ  = 32'h0000_0000,
  parameter logic [IRQ_W-1:0] LATCHED_IRQ = 32'hffff_ffff
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IRQ_W-1:0]        irq_in,
  input  logic                    timer_irq,
  input  logic                    ebreak_irq,
  input  logic                    buserror_irq,
  input  logic                    mask_wr,
  input  logic [IRQ_W-1:0]        mask_wdata,
  output logic [IRQ_W-1:0]        mask_q,
  output logic [IRQ_W-1:0]        pending_q,
  irq_latch_ctrl_if.master        core
);

  logic [IRQ_W-1:0] src;
  logic [IRQ_W-1:0] cand;
  logic [IRQ_W-1:0] clr;
  logic [IRQ_W-1:0] pending_d;
  logic             accept;

  logic [1:0]       state_q, state_d;
  irq_offer_t       offer_q, offer_d;
  logic             in_handler_q, in_handler_d;

  logic [NUM_W-1:0] enc_num_c;
  logic             enc_any_c;

  assign src = irq_in
             | (IRQ_W'(timer_irq)    << IRQ_TIMER)
             | (IRQ_W'(ebreak_irq)   << IRQ_EBREAK)
             | (IRQ_W'(buserror_irq) << IRQ_BUSERROR);

  assign cand   = pending_q & ~(mask_q | MASKED_IRQ);
  assign accept = (state_q == ST_OFFER) && core.irq_ready;

  // Acceptance clears only sticky bits; a same-cycle set re-pends the bit
  assign clr       = accept ? ((IRQ_W'(1) << offer_q.num) & LATCHED_IRQ) : '0;
  assign pending_d = (src & ~LATCHED_IRQ)
                   | (LATCHED_IRQ & (src | (pending_q & ~clr)));

  irq_prio_enc u_prio_enc (
    .vec   (cand),
    .num_c (enc_num_c),
    .any_c (enc_any_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q    <= MASK_RST;
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
      if (mask_wr) begin
        mask_q <= mask_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      offer_q      <= '0;
      in_handler_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      offer_q      <= offer_d;
      in_handler_q <= in_handler_d;
    end
  end

  // Ready beats withdrawal; irq_num stays frozen while an offer is outstanding
  always_comb begin
    state_d      = state_q;
    offer_d      = offer_q;
    in_handler_d = in_handler_q;
    case (state_q)
      ST_IDLE: begin
        if (enc_any_c) begin
          state_d       = ST_OFFER;
          offer_d.valid = 1'b1;
          offer_d.num   = enc_num_c;
        end
      end
      ST_OFFER: begin
        if (core.irq_ready) begin
          state_d       = ST_ACTIVE;
          offer_d.valid = 1'b0;
          in_handler_d  = 1'b1;
        end else if (!cand[offer_q.num]) begin
          state_d       = ST_IDLE;
          offer_d.valid = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (core.irq_done) begin
          state_d      = ST_IDLE;
          in_handler_d = 1'b0;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        offer_d.valid = 1'b0;
        in_handler_d  = 1'b0;
      end
    endcase
  end

  assign core.irq_valid  = offer_q.valid;
  assign core.irq_num    = offer_q.num;
  assign core.in_handler = in_handler_q;

endmodule

// File: doc/irq_latch_ctrl.md
Name: irq_latch_ctrl

Overview:
Interrupt front-end that sits directly upstream of the core's trap/IRQ entry logic. It samples 32 interrupt lines and merges in the internal timer, ebreak and bus-error sources on bits 0/1/2. It latches and masks the requests, then offers the lowest-numbered enabled pending IRQ to the core over a valid/ready handshake. It holds off further offers until the core retires the handler.

Parameters:
MASKED_IRQ, 32'h0000_0000, bits set here are permanently masked regardless of the mask register
LATCHED_IRQ, 32'hffff_ffff, bit=1: sticky (held until accepted); bit=0: level (pending follows input)
IRQ_TIMER, 0, bit index of the timer source
IRQ_EBREAK, 1, bit index of the ebreak source
IRQ_BUSERROR, 2, bit index of the bus-error source

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
irq_in  in  32  external interrupt lines, active high
timer_irq  in  1  ORed into bit IRQ_TIMER
ebreak_irq  in  1  ORed into bit IRQ_EBREAK
buserror_irq  in  1  ORed into bit IRQ_BUSERROR
mask_wr  in  1  write strobe for the mask register
mask_wdata  in  32  new mask value, 1 = masked
mask_q  out  32  current mask register
pending_q  out  32  current pending register
irq_valid  out  1  offer to core
irq_num  out  5  index of offered IRQ
irq_ready  in  1  core accepts offer
irq_done  in  1  core retires handler (retirq)
in_handler  out  1  high from accept until irq_done

Behaviour:
- Reset: mask_q=32'hffff_ffff, pending_q=0, irq_valid=0, irq_num=0, in_handler=0, FSM=IDLE.
- src = irq_in | internal sources at their indices.
- Sticky bits (LATCHED_IRQ=1): pending set when src=1; cleared only on acceptance of that bit.
- Level bits: pending_q[i] <= src[i] each cycle.
- Set and clear on the same bit in the same cycle: set wins, so a still-high line re-pends immediately.
- eff_mask = mask_q | MASKED_IRQ; cand = pending_q & ~eff_mask; selection is the lowest set index of cand.
- mask_wr updates mask_q next cycle and affects cand from that cycle on.
- FSM IDLE: if cand!=0, go to OFFER and register irq_num = lowest index.
- FSM OFFER: irq_valid=1; irq_num is frozen.
  - irq_ready=1: clear pending bit irq_num (sticky bits only), set in_handler, go to ACTIVE.
  - Offered bit no longer in cand (masked or level dropped) and irq_ready=0: withdraw, irq_valid=0 next cycle, go to IDLE.
  - Withdraw and ready in the same cycle: ready wins.
- FSM ACTIVE: irq_valid=0; pending continues to accumulate; no nesting.
  - irq_done: clear in_handler, go to IDLE. A new offer may appear the cycle after IDLE.
- irq_done outside ACTIVE is ignored. irq_ready outside OFFER is ignored.
- Latency: src rising at edge N → pending_q at N+1 → irq_valid at N+2.
- Reset mid-handshake (OFFER or ACTIVE) returns everything to reset values. The pending IRQ is lost.

Decomposition:
- Shared package: IRQ index constants (IRQ_TIMER/EBREAK/BUSERROR), 32-bit mask reset value, FSM state enum (IDLE/OFFER/ACTIVE).
- One sub-module: irq_prio_enc, a 32→5 lowest-index priority encoder plus any-bit flag, purely combinational.

Test Plan:
- Reset then irq_in=32'h0000_0010 with mask_q still all-ones → irq_valid stays 0 and pending_q=32'h10.
- mask_wdata=0, irq_in[4] pulsed 1 cycle → irq_valid=1, irq_num=4 two cycles later. Ready → pending_q[4]=0, in_handler=1. irq_done → in_handler=0.
- Bits 7 and 3 pending with mask=0 → irq_num=3 first. After done, irq_num=7 on the next offer.
- LATCHED_IRQ=32'hffff_fffe, irq_in[0] high for 1 cycle with no ready → offer withdrawn, irq_valid drops and the FSM returns to IDLE.
- In OFFER on bit 5, mask_wdata=32'h20 with irq_ready=0 → withdraw. Same with irq_ready=1 in the same cycle → accept wins.
- buserror_irq=1 while ACTIVE on bit 9 → no offer until irq_done, then irq_num=2. Assert reset in OFFER → all outputs return to reset values next cycle.
